// File: rtl/ddr3_bist_pkg.sv
// ddr3_bist_pkg: definitions shared by the DDR3 BIST initiator and its LFSR.
//   Provides the request command codes, the header length, the LFSR tap mask,
//   the FSM state encoding and the one-step Galois LFSR function.
package ddr3_bist_pkg;

   localparam logic [7:0] CMD_WRITE = 8'hA0;
   localparam logic [7:0] CMD_READ  = 8'hB0;
   localparam int         HDR_BYTES = 7;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR_HDR = 3'd1,
      ST_WR_DAT = 3'd2,
      ST_RD_HDR = 3'd3,
      ST_RD_DAT = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Right-shifting Galois step: the bit shifted out folds the tap mask back in.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/ddr3_bist_initiator_lfsr8_gen.sv
// lfsr8_gen: 8-bit Galois LFSR with synchronous reload.
//   clock   in  1  clock
//   rst_n   in  1  asynchronous active-low reset (value returns to SEED)
//   load    in  1  reload SEED (has priority over advance)
//   advance in  1  step the LFSR once
//   value   out 8  current LFSR value
module lfsr8_gen
   import ddr3_bist_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       load,
   input  logic       advance,
   output logic [7:0] value
);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)       value <= SEED;
      else if (load)    value <= SEED;
      else if (advance) value <= lfsr_next(value);
   end

endmodule

// File: rtl/ddr3_bist_initiator.sv
// ddr3_bist_initiator: BIST command source for the DDR3 core byte-stream port.
//   One run writes BURST_BYTES of LFSR data at base_addr_i, reads them back
//   and counts mismatching bytes, tlast framing errors and a read timeout.
// Ports:
//   clock, rst_n               clock, asynchronous active-low reset
//   start_i, base_addr_i       run request and its byte address
//   busy_o, done_o, pass_o     run status; done_o pulses once per run
//   err_count_o[15:0]          saturating error count of the last run
//   m_t*                       request stream (header + write payload)
//   s_t*                       read response stream (s_tkeep unused)
// Optional (macro DDR3_BIST_ERRLOG_EN): err_addr_o, err_exp_o, err_got_o hold
//   the first data mismatch of the run.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_WR_HDR | sending the 7-byte WRITE header
// ST_WR_DAT | sending LFSR payload, tlast on the last byte
// ST_RD_HDR | sending the 7-byte READ header, tlast on byte 6
// ST_RD_DAT | sinking and checking read data, idle timer running
// ST_DONE   | one-cycle done_o pulse, result valid
module ddr3_bist_initiator
   import ddr3_bist_pkg::*;
#(
   parameter int         BURST_BYTES    = 512,
   parameter logic [7:0] LFSR_SEED      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 65535
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_count_o,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        m_tkeep,
   output logic [7:0]  m_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   input  logic        s_tkeep,
   input  logic [7:0]  s_tdata
`ifdef DDR3_BIST_ERRLOG_EN
   ,
   output logic [31:0] err_addr_o,
   output logic [7:0]  err_exp_o,
   output logic [7:0]  err_got_o
`endif
);

   localparam logic [15:0] LAST_IDX = 16'(BURST_BYTES - 1);
   localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);
   localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
   // Reload one short so done_o lands TIMEOUT_CYCLES cycles after the last
   // accepted byte (the acceptance cycle itself counts as cycle 0).
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   state_t         state_q, state_d;
   logic [15:0]    cnt_q;
   logic [31:0]    addr_q;
   logic [15:0]    err_q, err_d;
   logic [16:0]    err_sum;
   logic [1:0]     err_inc;
   logic           pass_q;
   logic [TW-1:0]  idle_q;
   logic [7:0]     lfsr_val, hdr_byte;
   logic           lfsr_load, lfsr_adv;
   logic           start_ok, m_xfer, s_xfer, hdr_end, dat_end;
   logic           timeout, byte_bad, tlast_bad;
   logic           unused_keep;

   assign unused_keep = s_tkeep;

   assign start_ok  = start_i && (state_q == ST_IDLE);
   assign m_xfer    = m_tvalid && m_tready;
   assign s_xfer    = s_tvalid && s_tready;
   assign hdr_end   = (cnt_q == HDR_LAST);
   assign dat_end   = (cnt_q == LAST_IDX);
   assign byte_bad  = s_xfer && (s_tdata != lfsr_val);
   assign tlast_bad = s_xfer && (s_tlast != dat_end);
   assign timeout   = (state_q == ST_RD_DAT) && !s_xfer && (idle_q <= TW'(1));

   assign busy_o      = (state_q != ST_IDLE);
   assign pass_o      = pass_q;
   assign err_count_o = err_q;
   assign m_tkeep     = m_tvalid;

   lfsr8_gen #(.SEED(LFSR_SEED)) u_lfsr (
      .clock   (clock),
      .rst_n   (rst_n),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .value   (lfsr_val)
   );

   assign lfsr_load = start_ok || ((state_q == ST_RD_HDR) && (state_d == ST_RD_DAT));
   assign lfsr_adv  = ((state_q == ST_WR_DAT) && m_xfer) || s_xfer;

   always_comb begin
      hdr_byte = 8'h00;
      case (cnt_q)
         16'd0:   hdr_byte = (state_q == ST_RD_HDR) ? CMD_READ : CMD_WRITE;
         16'd1:   hdr_byte = addr_q[7:0];
         16'd2:   hdr_byte = addr_q[15:8];
         16'd3:   hdr_byte = addr_q[23:16];
         16'd4:   hdr_byte = addr_q[31:24];
         16'd5:   hdr_byte = LAST_IDX[7:0];
         default: hdr_byte = LAST_IDX[15:8];
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      m_tdata  = 8'h00;
      s_tready = 1'b0;
      done_o   = 1'b0;
      case (state_q)
         ST_IDLE: if (start_ok) state_d = ST_WR_HDR;
         ST_WR_HDR: begin
            m_tvalid = 1'b1;
            m_tdata  = hdr_byte;
            if (m_xfer && hdr_end) state_d = ST_WR_DAT;
         end
         ST_WR_DAT: begin
            m_tvalid = 1'b1;
            m_tdata  = lfsr_val;
            m_tlast  = dat_end;
            if (m_xfer && dat_end) state_d = ST_RD_HDR;
         end
         ST_RD_HDR: begin
            m_tvalid = 1'b1;
            m_tdata  = hdr_byte;
            m_tlast  = hdr_end;
            if (m_xfer && hdr_end) state_d = ST_RD_DAT;
         end
         ST_RD_DAT: begin
            s_tready = 1'b1;
            // Early tlast, missing tlast and the normal end all finish the run.
            if ((s_xfer && (s_tlast || dat_end)) || timeout) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      err_inc = 2'(byte_bad) + 2'(tlast_bad) + 2'(timeout);
      err_sum = {1'b0, err_q} + {15'd0, err_inc};
      err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (start_ok) err_d = 16'h0000;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 16'h0000;
         addr_q <= 32'h0000_0000;
         err_q  <= 16'h0000;
         pass_q <= 1'b0;
         idle_q <= TO_LOAD;
      end else begin
         err_q <= err_d;
         if (start_ok) addr_q <= base_addr_i;

         if (state_d != state_q)   cnt_q <= 16'h0000;
         else if (m_xfer || s_xfer) cnt_q <= cnt_q + 16'd1;

         if ((state_q != ST_RD_DAT) || s_xfer) idle_q <= TO_LOAD;
         else                                  idle_q <= idle_q - TW'(1);

         if (start_ok)
            pass_q <= 1'b0;
         else if ((state_q == ST_RD_DAT) && (state_d == ST_DONE))
            pass_q <= (err_d == 16'h0000);
      end
   end

`ifdef DDR3_BIST_ERRLOG_EN
   logic logged_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         logged_q   <= 1'b0;
         err_addr_o <= 32'h0000_0000;
         err_exp_o  <= 8'h00;
         err_got_o  <= 8'h00;
      end else if (start_ok) begin
         logged_q   <= 1'b0;
         err_addr_o <= 32'h0000_0000;
         err_exp_o  <= 8'h00;
         err_got_o  <= 8'h00;
      end else if (byte_bad && !logged_q) begin
         logged_q   <= 1'b1;
         err_addr_o <= addr_q + {16'h0000, cnt_q};
         err_exp_o  <= lfsr_val;
         err_got_o  <= s_tdata;
      end
   end
`endif

endmodule

// File: tb/tb_ddr3_bist_initiator.sv
// tb_ddr3_bist_initiator: directed bench with a loopback DDR3 core model and
//   a scoreboard. Stimulus pushes the expected request bytes and run results;
//   a negedge monitor pops and compares on every m_ handshake and done_o.
//   Optional macro DDR3_BIST_ERRLOG_EN also checks the error-log ports.
module tb_ddr3_bist_initiator;

   localparam int BURST = 4;
   localparam int TMO   = 100;

   logic        clock = 1'b0;
   logic        rst_n, start_i;
   logic [31:0] base_addr_i;
   logic        busy_o, done_o, pass_o;
   logic [15:0] err_count_o;
   logic        m_tvalid, m_tready, m_tlast, m_tkeep;
   logic [7:0]  m_tdata;
   logic        s_tvalid, s_tready, s_tlast, s_tkeep;
   logic [7:0]  s_tdata;
`ifdef DDR3_BIST_ERRLOG_EN
   logic [31:0] err_addr;
   logic [7:0]  err_exp, err_got;
`endif

   always #5 clock = ~clock;

   ddr3_bist_initiator #(.BURST_BYTES(BURST), .LFSR_SEED(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
      .m_tdata(m_tdata),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
      .s_tdata(s_tdata)
`ifdef DDR3_BIST_ERRLOG_EN
      , .err_addr_o(err_addr), .err_exp_o(err_exp), .err_got_o(err_got)
`endif
   );

   typedef struct {
      logic [15:0] err;
      logic        pass;
      logic        chk_log;
      logic [31:0] addr;
      logic [7:0]  exp;
      logic [7:0]  got;
   } res_t;

   // Hand-computed Galois LFSR (taps B8) sequence from seed A5.
   logic [7:0] pay [BURST] = '{8'hA5, 8'hEA, 8'h75, 8'h82};

   logic [9:0] exp_m_q [$];   // {read-header end, tlast, data}
   res_t       exp_res_q [$];
   logic [8:0] resp_q [$];    // {tlast, data}
   logic [7:0] mem [logic [31:0]];

   int n_tests = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, rd_tlast_cyc = 0, rd_tlast_cnt = 0, m_seen = 0;
   int corrupt_idx = -1, early_idx = -1;
   bit no_resp = 0, rand_ready = 0, gaps = 0;
   bit s_hs = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Loopback core model: parses request frames, stores writes, queues reads.
   int          fidx = 0;
   logic [7:0]  fcmd;
   logic [31:0] faddr;
   logic [15:0] flen;
   always @(negedge clock) begin
      if (!rst_n) begin
         fidx = 0;
         resp_q.delete();
         s_hs = 0;
      end else begin
         s_hs = s_tvalid && s_tready;
         if (m_tvalid && m_tready) begin
            case (fidx)
               0: fcmd = m_tdata;
               1: faddr[7:0] = m_tdata;
               2: faddr[15:8] = m_tdata;
               3: faddr[23:16] = m_tdata;
               4: faddr[31:24] = m_tdata;
               5: flen[7:0] = m_tdata;
               6: flen[15:8] = m_tdata;
               default: mem[faddr + 32'(fidx - 7)] = m_tdata;
            endcase
            if (m_tlast) begin
               if (fcmd == 8'hB0 && !no_resp) begin
                  for (int i = 0; i <= int'(flen); i++) begin
                     logic [7:0] d;
                     logic       l;
                     d = mem[faddr + 32'(i)];
                     if (i == corrupt_idx) d = d ^ 8'h01;
                     l = (early_idx >= 0) ? (i == early_idx) : (i == int'(flen));
                     resp_q.push_back({l, d});
                     if (l) break;
                  end
               end
               fidx = 0;
            end else begin
               fidx++;
            end
         end
      end
   end

   // Response/ready driver, updated just after each rising edge.
   initial begin
      s_tvalid = 0; s_tlast = 0; s_tdata = 0; s_tkeep = 1; m_tready = 1;
      forever begin
         @(posedge clock); #1;
         if (!rst_n) begin
            s_tvalid = 0;
         end else begin
            if (s_hs && resp_q.size() > 0) void'(resp_q.pop_front());
            if (!s_tvalid || s_hs)
               s_tvalid = (resp_q.size() > 0) && (!gaps || $urandom_range(0, 1) == 1);
            if (resp_q.size() > 0) {s_tlast, s_tdata} = resp_q[0];
            m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clock) begin
      cyc++;
      if (rst_n) begin
         if (m_tvalid && m_tready) begin
            m_seen++;
            if (exp_m_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL m_extra: got byte %h expected no transfer", m_tdata);
            end else begin
               logic [9:0] e;
               e = exp_m_q.pop_front();
               check("m_tdata", {24'h0, m_tdata}, {24'h0, e[7:0]});
               check("m_tlast", {31'h0, m_tlast}, {31'h0, e[8]});
               check("m_tkeep", {31'h0, m_tkeep}, 32'h1);
               if (e[9]) begin rd_tlast_cyc = cyc; rd_tlast_cnt++; end
            end
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_res_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL done_extra: got done_o=1 expected none");
            end else begin
               res_t r;
               r = exp_res_q.pop_front();
               check("err_count", {16'h0, err_count_o}, {16'h0, r.err});
               check("pass", {31'h0, pass_o}, {31'h0, r.pass});
               check("busy_in_done", {31'h0, busy_o}, 32'h1);
               check("s_tready_in_done", {31'h0, s_tready}, 32'h0);
`ifdef DDR3_BIST_ERRLOG_EN
               if (r.chk_log) begin
                  check("err_addr", err_addr, r.addr);
                  check("err_exp", {24'h0, err_exp}, {24'h0, r.exp});
                  check("err_got", {24'h0, err_got}, {24'h0, r.got});
               end
`endif
            end
         end
      end
   end

   task automatic push_hdr(input logic [7:0] cmd, input logic [31:0] a, input bit rd);
      exp_m_q.push_back({2'b00, cmd});
      exp_m_q.push_back({2'b00, a[7:0]});
      exp_m_q.push_back({2'b00, a[15:8]});
      exp_m_q.push_back({2'b00, a[23:16]});
      exp_m_q.push_back({2'b00, a[31:24]});
      exp_m_q.push_back({2'b00, 8'h03});
      exp_m_q.push_back({rd, rd, 8'h00});
   endtask

   task automatic push_run(input logic [31:0] a, input logic [15:0] err, input bit pass,
                           input bit chk_log, input logic [31:0] la,
                           input logic [7:0] le, input logic [7:0] lg);
      res_t r;
      push_hdr(8'hA0, a, 0);
      for (int i = 0; i < BURST; i++) exp_m_q.push_back({1'b0, i == BURST - 1, pay[i]});
      push_hdr(8'hB0, a, 1);
      r.err = err; r.pass = pass; r.chk_log = chk_log; r.addr = la; r.exp = le; r.got = lg;
      exp_res_q.push_back(r);
   endtask

   task automatic pulse_start(input logic [31:0] a);
      @(posedge clock); #1;
      start_i = 1; base_addr_i = a;
      @(posedge clock); #1;
      start_i = 0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 2000) begin @(posedge clock); n++; end
      if (done_cnt == d0) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: got no done_o expected done within 2000 cycles", name);
      end
   endtask

   task automatic finish_run(input int d0, input string name);
      repeat (5) @(posedge clock);
      #1;
      check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'h1);
      check({name, "_busy_after"}, {31'h0, busy_o}, 32'h0);
      check({name, "_m_left"}, 32'(exp_m_q.size()), 32'h0);
      check({name, "_res_left"}, 32'(exp_res_q.size()), 32'h0);
   endtask

   task automatic run(input logic [31:0] a, input logic [15:0] err, input bit pass,
                      input bit chk_log, input logic [31:0] la, input logic [7:0] le,
                      input logic [7:0] lg, input string name);
      int d0;
      d0 = done_cnt;
      push_run(a, err, pass, chk_log, la, le, lg);
      pulse_start(a);
      wait_done(d0, name);
      finish_run(d0, name);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_busy"}, {31'h0, busy_o}, 32'h0);
      check({name, "_done"}, {31'h0, done_o}, 32'h0);
      check({name, "_pass"}, {31'h0, pass_o}, 32'h0);
      check({name, "_err"}, {16'h0, err_count_o}, 32'h0);
      check({name, "_m_tvalid"}, {31'h0, m_tvalid}, 32'h0);
      check({name, "_s_tready"}, {31'h0, s_tready}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected end before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, t0, n, m0;
      rst_n = 0; start_i = 0; base_addr_i = 0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      rst_n = 1;

      // 1: clean loopback run
      run(32'h0000_1000, 16'd0, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0, "t1");

      // 2: byte 2 corrupted by the core
      corrupt_idx = 2;
      run(32'h0000_1000, 16'd1, 1'b0, 1'b1, 32'h0000_1002, 8'h75, 8'h74, "t2");
      corrupt_idx = -1;

      // 4: no read data -> timeout; start_i coincident with DONE is ignored
      no_resp = 1;
      d0 = done_cnt;
      t0 = rd_tlast_cnt;
      push_run(32'h0000_2000, 16'd1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
      pulse_start(32'h0000_2000);
      n = 0;
      while (rd_tlast_cnt == t0 && n < 200) begin @(posedge clock); n++; end
      check("t4_rd_tlast_seen", 32'(rd_tlast_cnt - t0), 32'h1);
      n = 0;
      do begin @(posedge clock); n++; end while (cyc < rd_tlast_cyc + 99 && n < 300);
      #1 start_i = 1; base_addr_i = 32'h0000_3000;
      @(posedge clock); #1 start_i = 0;
      wait_done(d0, "t4");
      check("t4_done_latency", 32'(done_cyc - rd_tlast_cyc), 32'd100);
      finish_run(d0, "t4");
      no_resp = 0;

      // 5: s_tlast on byte 1 of 4
      early_idx = 1;
      run(32'h0000_1000, 16'd1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0, "t5");
      check("t5_s_tready_after", {31'h0, s_tready}, 32'h0);
      early_idx = -1;

      // 3: random m_tready, s_tvalid gaps, start_i while busy ignored
      rand_ready = 1; gaps = 1;
      d0 = done_cnt;
      push_run(32'h0000_1000, 16'd0, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      pulse_start(32'h0000_1000);
      repeat (4) @(posedge clock);
      pulse_start(32'h0000_5555);
      wait_done(d0, "t3");
      finish_run(d0, "t3");
      rand_ready = 0; gaps = 0;

      // 6: reset during WR_DAT, then a fresh run
      m0 = m_seen;
      push_run(32'h0000_1000, 16'd0, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      pulse_start(32'h0000_1000);
      n = 0;
      while (m_seen < m0 + 9 && n < 200) begin @(posedge clock); n++; end
      check("t6_reached_wr_dat", {31'h0, m_seen >= m0 + 9}, 32'h1);
      @(posedge clock); #1 rst_n = 0;
      #1;
      check_reset_outputs("t6_rst");
      exp_m_q.delete();
      exp_res_q.delete();
      repeat (2) @(posedge clock);
      #1;
      check_reset_outputs("t6_rst_hold");
      rst_n = 1;
      run(32'h0000_1000, 16'd0, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0, "t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
